fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the flat RISC-V pipeline. It sits directly upstream of the register-read stage. It keeps the fetch PC and issues word requests to instruction memory. Returned instructions are held in a 2-entry prefetch buffer and presented as IR_out/PC_out with the pipeline valid/ready handshake. Taken-branch/jump redirects flush all wrong-path state.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset (word aligned)
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address, bits [1:0] always 00
- imem_gnt  in  1  request accepted this cycle (accept = imem_req & imem_gnt)
- imem_rvalid  in  1  response valid; exactly 1 cycle after each accept, in order
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- redirect  in  1  control transfer from execute; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00)
- stall  in  1  pipeline freeze, shared with read stage
- r_in  in  1  downstream ready (read stage r_out)
- v_out  out  1  IR_out/PC_out valid
- IR_out  out  32  instruction at buffer head
- PC_out  out  32  address of IR_out

## Operation
- State: fetch_pc (32), buffer of 2 {IR,PC} entries (head/tail pointers, occ 0..2), outst (0..1), per-request PC tag register.
- pop = v_out & r_in. v_out = (occ != 0) & ~stall. IR_out/PC_out = head entry; when occ==0 they hold the last head value and are don't-care.
- Credit: imem_req = ~redirect & ((occ + outst - pop) < 2). imem_req may depend combinationally on r_in and stall.
- imem_addr = fetch_pc. On accept: fetch_pc <= fetch_pc + 4 (mod 2^32, wraps FFFFFFFC -> 00000000); tag <= fetch_pc; outst <= 1.
- Once raised without grant, imem_req/imem_addr hold stable until accepted. The only exception is redirect, which may withdraw them.
- On imem_rvalid (no redirect): push {imem_rdata, tag} at tail; outst clears unless a new accept occurs the same cycle.
- Push and pop in the same cycle: occ unchanged; both pointers advance. Credit guarantees no push when full without a pop.
- Redirect (highest priority): occ <= 0, pointers <= 0, outst <= 0, fetch_pc <= {redirect_pc[31:2],2'b00}. Any imem_rvalid that cycle is discarded. imem_req=0 and v_out is still computed, but any pop that cycle is irrelevant because the buffer is flushed. Redirect under stall is still honoured.
- stall: no pop and v_out=0. Requests continue within credit and responses are still buffered.

## Timing
- Reset (async, rst_n=0): fetch_pc=RESET_PC, occ=0, outst=0, pointers=0, v_out=0, imem_req=0, IR_out=0, PC_out=0.
- First imem_req=1 in the first cycle after rst_n rises, addr=RESET_PC.
- Latency: accept at cycle N -> rvalid at N+1 -> v_out=1 at N+2, with IR_out from the buffer register.
- Sustained throughput: 1 instruction/cycle when gnt and r_in are held high.
- Redirect at cycle N -> imem_req with redirect_pc at N+1 -> earliest v_out at N+3.
- Reset asserted mid-operation: immediate return to the reset values above. In-flight responses arriving after rst_n rises without an accept are ignored (outst=0).

## Test plan
- Reset, RESET_PC=0x100, gnt=1, rvalid follows, r_in=1 -> PC_out sequence 0x100,0x104,0x108, one per cycle, first v_out 2 cycles after first accept.
- r_in=0 for 5 cycles -> exactly 2 words buffered, imem_req drops to 0. r_in=1 -> in-order delivery, no loss or duplication, imem_req reasserts the same cycle.
- gnt=0 for 3 cycles -> imem_req=1 and imem_addr held constant. Grant -> that address delivered once.
- redirect with redirect_pc=0x203 while buffer full and response in flight -> response dropped, next IR_out has PC_out=0x200, no old-path word ever valid.
- stall=1 for 4 cycles with r_in=1 -> v_out=0, buffer fills to 2. Release -> stream resumes in order.
- fetch_pc=0xFFFFFFFC -> next PC_out 0x00000000. rst_n pulsed low mid-stream -> v_out=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to
// instruction memory and holds returned words in a 2-entry prefetch buffer
// that is presented downstream with a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        r_in,
    output logic        v_out,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out
);

    logic [31:0] fetch_pc;
    logic [31:0] tag_pc;
    logic [31:0] ir_buf [2];
    logic [31:0] pc_buf [2];
    logic        head;
    logic        tail;
    logic [1:0]  occ;
    logic        outst;

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  credit_used;
    logic [31:0] redirect_aligned;

    // Handshake, credit and request generation.
    always_comb begin
        v_out            = (occ != 2'd0) & ~stall;
        pop              = v_out & r_in;
        // Words already buffered or in flight, minus the one leaving now.
        // Keeping this below 2 guarantees every response finds a free slot.
        credit_used      = {1'b0, occ} + {2'b00, outst} - {2'b00, pop};
        imem_req         = rst_n & ~redirect & (credit_used < 3'd2);
        imem_addr        = fetch_pc;
        accept           = imem_req & imem_gnt;
        // A response is only ours if a request is outstanding; this drops
        // stray responses to requests issued before a reset.
        push             = imem_rvalid & outst & ~redirect;
        redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
        IR_out           = ir_buf[head];
        PC_out           = pc_buf[head];
    end

    // Fetch PC, request tracking and prefetch buffer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            tag_pc    <= 32'h0;
            head      <= 1'b0;
            tail      <= 1'b0;
            occ       <= 2'd0;
            outst     <= 1'b0;
            // NOTE: the two buffer entries are reset because the head entry
            // drives IR_out/PC_out directly and those must read 0 in reset.
            ir_buf[0] <= 32'h0;
            ir_buf[1] <= 32'h0;
            pc_buf[0] <= 32'h0;
            pc_buf[1] <= 32'h0;
        end else if (redirect) begin
            // Flush everything on the wrong path and restart at the target.
            fetch_pc <= redirect_aligned;
            head     <= 1'b0;
            tail     <= 1'b0;
            occ      <= 2'd0;
            outst    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every update below read the
            // pre-edge values, so push/pop/accept in one cycle compose cleanly.
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_pc   <= fetch_pc;
                outst    <= 1'b1;
            end else if (push) begin
                outst <= 1'b0;
            end

            if (push) begin
                ir_buf[tail] <= imem_rdata;
                pc_buf[tail] <= tag_pc;
                tail         <= ~tail;
            end

            if (pop) begin
                head <= ~head;
            end

            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed per-cycle vector table,
// hand-written redirect/wrap/reset sequences, and a randomized run checked
// against a queue-based model of the prefetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        r_in;
    logic        v_out;
    logic [31:0] IR_out;
    logic [31:0] PC_out;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .r_in        (r_in),
        .v_out       (v_out),
        .IR_out      (IR_out),
        .PC_out      (PC_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a distinct instruction word per address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) + 32'h0000_0013;
    endfunction

    // Reference model: PCs waiting in the buffer, PCs requested but not yet
    // returned, and the next address fetch should ask for.
    logic [31:0] bufq[$];
    logic [31:0] inflight[$];
    logic [31:0] m_fetch_pc;

    // Memory responder state and per-cycle sampled outputs.
    logic        rv_next;
    logic [31:0] rd_next;
    logic        s_v;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_ir;

    task automatic model_reset();
        bufq.delete();
        inflight.delete();
        m_fetch_pc = RPC;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample, check
    // against the model, update the model, then wait for the next falling edge.
    task automatic tick(input logic g, input logic ri, input logic st,
                        input logic rd, input logic [31:0] rp);
        bit ev;
        bit pp;
        bit er;
        imem_gnt    = g;
        r_in        = ri;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        imem_rvalid = rv_next;
        imem_rdata  = rd_next;
        #1;
        s_v    = v_out;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_pc   = PC_out;
        s_ir   = IR_out;

        ev = (bufq.size() != 0) && !st;
        check("model v_out", 32'(s_v), 32'(ev));
        if (ev && s_v) begin
            check("model PC_out", s_pc, bufq[0]);
            check("model IR_out", s_ir, instr_of(bufq[0]));
        end
        pp = ev && ri;
        er = !rd && ((bufq.size() + inflight.size() - (pp ? 1 : 0)) < 2);
        check("model imem_req", 32'(s_req), 32'(er));
        if (s_req) check("model imem_addr", s_addr, m_fetch_pc);

        if (rd) begin
            bufq.delete();
            inflight.delete();
            m_fetch_pc = {rp[31:2], 2'b00};
        end else begin
            if (pp) void'(bufq.pop_front());
            if (rv_next && inflight.size() != 0) bufq.push_back(inflight.pop_front());
            if (s_req && g) begin
                inflight.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        rv_next = s_req && g;
        rd_next = instr_of(s_addr);
        @(negedge clk);
    endtask

    // Redirect, then check the N+1 request and the N+3 first valid word.
    task automatic redirect_seq(input logic [31:0] rp, input logic ri_at, input logic st_at);
        logic [31:0] tgt;
        tgt = {rp[31:2], 2'b00};
        tick(1'b1, ri_at, st_at, 1'b1, rp);
        check("redirect cycle imem_req", 32'(s_req), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redirect N+1 imem_req", 32'(s_req), 32'd1);
        check("redirect N+1 imem_addr", s_addr, tgt);
        check("redirect N+1 v_out", 32'(s_v), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redirect N+2 v_out", 32'(s_v), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redirect N+3 v_out", 32'(s_v), 32'd1);
        check("redirect N+3 PC_out", s_pc, tgt);
        check("redirect N+3 IR_out", s_ir, instr_of(tgt));
    endtask

    typedef struct {
        logic        gnt;
        logic        r_in;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic g, input logic ri, input logic st, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.r_in = ri; v.stall = st;
        v.exp_req = er; v.exp_addr = ea; v.exp_v = ev; v.exp_pc = ep;
        tbl.push_back(v);
    endtask

    initial begin
        // Startup stream: first valid two cycles after the first accept.
        add(1, 1, 0, 1, 32'h100, 0, 32'h0);
        add(1, 1, 0, 1, 32'h104, 0, 32'h0);
        add(1, 1, 0, 1, 32'h108, 1, 32'h100);
        add(1, 1, 0, 1, 32'h10C, 1, 32'h104);
        add(1, 1, 0, 1, 32'h110, 1, 32'h108);
        // Downstream not ready for 5 cycles: buffer fills to 2, requests stop.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 32'h0, 1, 32'h10C);
        // Ready again: request reasserts immediately, order preserved.
        add(1, 1, 0, 1, 32'h114, 1, 32'h10C);
        add(1, 1, 0, 1, 32'h118, 1, 32'h110);
        add(1, 1, 0, 1, 32'h11C, 1, 32'h114);
        // No grant for 3 cycles: address held at 0x120.
        add(0, 1, 0, 1, 32'h120, 1, 32'h118);
        add(0, 1, 0, 1, 32'h120, 1, 32'h11C);
        add(0, 1, 0, 1, 32'h120, 0, 32'h0);
        add(1, 1, 0, 1, 32'h120, 0, 32'h0);
        add(1, 1, 0, 1, 32'h124, 0, 32'h0);
        add(1, 1, 0, 1, 32'h128, 1, 32'h120);
        add(1, 1, 0, 1, 32'h12C, 1, 32'h124);
        // Stall for 4 cycles: nothing valid, buffer fills, requests stop.
        for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 32'h0, 0, 32'h0);
        add(1, 1, 0, 1, 32'h130, 1, 32'h128);
        add(1, 1, 0, 1, 32'h134, 1, 32'h12C);
        add(1, 1, 0, 1, 32'h138, 1, 32'h130);

        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        r_in        = 1'b0;
        rv_next     = 1'b0;
        rd_next     = 32'h0;
        repeat (2) @(negedge clk);
        check("reset v_out", 32'(v_out), 32'd0);
        check("reset imem_req", 32'(imem_req), 32'd0);
        check("reset IR_out", IR_out, 32'h0);
        check("reset PC_out", PC_out, 32'h0);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].gnt, tbl[i].r_in, tbl[i].stall, 1'b0, 32'h0);
            check($sformatf("row%0d imem_req", i), 32'(s_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) check($sformatf("row%0d imem_addr", i), s_addr, tbl[i].exp_addr);
            check($sformatf("row%0d v_out", i), 32'(s_v), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                check($sformatf("row%0d PC_out", i), s_pc, tbl[i].exp_pc);
                check($sformatf("row%0d IR_out", i), s_ir, instr_of(tbl[i].exp_pc));
            end
        end

        // Redirect while a response is in flight; target low bits ignored.
        redirect_seq(32'h0000_0203, 1'b1, 1'b0);
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        // Redirect with a full buffer and ready low, then one under stall.
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        redirect_seq(32'h0000_0300, 1'b0, 1'b0);
        repeat (2) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        redirect_seq(32'h0000_0400, 1'b1, 1'b1);

        // Address wrap: FFFFFFF8, FFFFFFFC, then 00000000.
        redirect_seq(32'hFFFF_FFF9, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap PC_out FFFFFFFC", s_pc, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap v_out", 32'(s_v), 32'd1);
        check("wrap PC_out 0", s_pc, 32'h0000_0000);
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-stream, with a stray response afterwards.
        #2 rst_n = 1'b0;
        #1;
        check("midreset v_out", 32'(v_out), 32'd0);
        check("midreset imem_req", 32'(imem_req), 32'd0);
        check("midreset PC_out", PC_out, 32'h0);
        check("midreset IR_out", IR_out, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rv_next = 1'b1;
        rd_next = 32'hDEAD_DEAD;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("restart imem_req", 32'(s_req), 32'd1);
        check("restart imem_addr", s_addr, RPC);
        check("restart v_out c0", 32'(s_v), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("restart v_out c1", 32'(s_v), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("restart v_out c2", 32'(s_v), 32'd1);
        check("restart PC_out", s_pc, RPC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        g;
            logic        ri;
            logic        st;
            logic        rd;
            logic [31:0] rp;
            g  = ($urandom_range(0, 3) != 0);
            ri = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 6) == 0);
            rd = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else rp = $urandom;
            tick(g, ri, st, rd, rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
